rca16_seq_ctrl: RTL and testbench

Sequencing stage directly upstream of the 16-bit switch-level ripple-carry adder built from the xor/nand/nmos-pmos cells.
- Accepts operand pairs on a valid/ready handshake and drives them into the adder as registered, stable inputs.
- Holds the inputs for a programmed number of settle cycles, which covers the adder's long ripple delay, then captures sum and carry-out.
- Presents the result, with a signed-overflow flag, on a second valid/ready handshake.

---
 rtl/rca16_seq_ctrl.sv | 115 +++++++++++
 tb/tb_rca16_seq_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/rca16_seq_ctrl.sv
// Sequencer feeding a ripple-carry adder: registers operands, waits SETTLE cycles, captures sum/cout/ovf.
// Optional accumulate mode (add_a from last captured sum) enabled by defining RCA_ACC_EN.
module rca16_seq_ctrl #(
  parameter int WIDTH  = 16,
  parameter int SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef RCA_ACC_EN
  input  logic             in_acc,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  localparam int SET_EFF = (SETTLE < 1) ? 1 : SETTLE;
  localparam int CW      = (SET_EFF + 1 > 2) ? $clog2(SET_EFF + 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SET_EFF - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            accept, capture;
  logic [WIDTH-1:0] sel_a;

`ifdef RCA_ACC_EN
  logic [WIDTH-1:0] acc_q;
  assign sel_a = in_acc ? acc_q : in_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc_q <= '0;
    else if (capture) acc_q <= add_sum;
  end
`else
  assign sel_a = in_a;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);

  // add_* deliberately keep their value in IDLE so the adder does not toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      cnt_q    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else begin
      if (accept) begin
        add_a   <= sel_a;
        add_b   <= in_b;
        add_cin <= in_cin;
        cnt_q   <= CNT_LOAD;
      end else if (state_q == ST_SETTLE && cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_ONE;
      end
      if (capture) begin
        out_sum  <= add_sum;
        out_cout <= add_cout;
        out_ovf  <= (add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                    (add_sum[WIDTH-1] != add_a[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_rca16_seq_ctrl.sv
// Scoreboard bench for rca16_seq_ctrl with a behavioural adder behind the add_* ports.
module tb_rca16_seq_ctrl;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_cin;
  logic [15:0] in_a, in_b;
  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic        out_valid, out_ready, out_cout, out_ovf, busy;
  logic [15:0] out_sum;
`ifdef RCA_ACC_EN
  logic        in_acc;
`endif

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {16'd0, add_cin};

  rca16_seq_ctrl #(.WIDTH(16), .SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef RCA_ACC_EN
    .in_acc(in_acc),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .busy(busy)
  );

  res_t        sb[$];
  string       nm_q[$];
  logic [31:0] act_q[$], exp_q[$];
  logic        done = 1'b0;
  int          total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    nm_q.push_back(n);
    act_q.push_back(act);
    exp_q.push_back(exp);
  endtask

  task automatic expect_res(input logic [15:0] s, input logic c, input logic o);
    res_t r;
    r.sum = s; r.cout = c; r.ovf = o;
    sb.push_back(r);
  endtask

  // Presents an operand (assumed called #1 after a rising edge) and waits for the accept edge.
  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic c);
    bit ok = 0;
    in_a = a; in_b = b; in_cin = c; in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        ok = 1;
      end
    end
    if (!ok) begin
      in_valid = 1'b0;
      chk("accept_timeout", 0, 1);
    end
  endtask

  task automatic wait_result(input string n);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    if (!seen) chk(n, 0, 1);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                      input logic [15:0] s, input logic co, input logic o);
    accept(a, b, c);
    expect_res(s, co, o);
    wait_result("result_timeout");
  endtask

  // Monitor: drains directed checks and scores every consumed result.
  string       m_n;
  logic [31:0] m_a, m_e;
  res_t        m_r;
  always @(negedge clk) begin
    while (nm_q.size() > 0) begin
      m_n = nm_q.pop_front(); m_a = act_q.pop_front(); m_e = exp_q.pop_front();
      total++;
      if (m_a !== m_e) begin
        bad++;
        $display("FAIL %s: got %0h want %0h", m_n, m_a, m_e);
      end
    end
    if (rst_n && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got sum %0h with no result pending", out_sum);
      end else begin
        m_r = sb.pop_front();
        if (out_sum !== m_r.sum) begin
          bad++; $display("FAIL out_sum: got %0h want %0h", out_sum, m_r.sum);
        end
        total++;
        if (out_cout !== m_r.cout) begin
          bad++; $display("FAIL out_cout: got %0b want %0b", out_cout, m_r.cout);
        end
        total++;
        if (out_ovf !== m_r.ovf) begin
          bad++; $display("FAIL out_ovf: got %0b want %0b", out_ovf, m_r.ovf);
        end
      end
    end
    if (done) begin
      total++;
      if (sb.size() != 0) begin
        bad++;
        $display("FAIL results_missing: got %0d pending want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
`ifdef RCA_ACC_EN
    in_acc = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_out_sum", out_sum, 0);
    @(posedge clk); #1;

    // Basic add with latency check: four negedges without out_valid, then valid.
    accept(16'h1234, 16'h0001, 1'b0);
    expect_res(16'h1235, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("settle_in_ready", in_ready, 0);
      chk("settle_out_valid", out_valid, 0);
    end
    @(negedge clk);
    chk("latency_out_valid", out_valid, 1);
    @(posedge clk); #1;

    send(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    send(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    send(16'h00FF, 16'h0000, 1'b1, 16'h0100, 1'b0, 1'b0);

    // Backpressure: result held, second operand waits until the result is consumed.
    out_ready = 1'b0;
    accept(16'h0100, 16'h0200, 1'b0);
    expect_res(16'h0300, 1'b0, 1'b0);
    in_a = 16'h0005; in_b = 16'h0006; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    chk("blocked_in_ready", in_ready, 0);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (out_valid) seen = 1;
      end
      if (!seen) chk("bp_result_timeout", 0, 1);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_sum", out_sum, 16'h0300);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_add_a", add_a, 16'h0100);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("idle_after_consume", in_ready, 1);
    @(posedge clk); #1 in_valid = 1'b0;
    expect_res(16'h000B, 1'b0, 1'b0);
    @(negedge clk);
    chk("second_add_a", add_a, 16'h0005);
    wait_result("second_result_timeout");

    // Reset two cycles after accept: everything clears and nothing is emitted.
    accept(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_add_a", add_a, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("midrst_no_result", out_valid, 0);
    end
    @(posedge clk); #1;
    send(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);

    // Accumulate sequence; without the feature the second add uses in_a = 0.
    send(16'h0010, 16'h0005, 1'b0, 16'h0015, 1'b0, 1'b0);
`ifdef RCA_ACC_EN
    in_acc = 1'b1;
    send(16'h0000, 16'h0001, 1'b0, 16'h0016, 1'b0, 1'b0);
    in_acc = 1'b0;
`else
    send(16'h0000, 16'h0001, 1'b0, 16'h0001, 1'b0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    @(posedge clk); #1 done = 1'b1;
  end

endmodule
